// File: rtl/decode_stage_if.sv
// Fetch-to-decode handshake bundle.
// Fetch drives the word; decode answers with ready.
interface decode_stage_if;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] if_inst;
  logic [15:0] if_pc1;

  modport master (
    output if_valid, if_inst, if_pc1,
    input  if_ready
  );

  modport slave (
    input  if_valid, if_inst, if_pc1,
    output if_ready
  );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: field split, operand forming, ID/EX slot,
// load-use stall, flush squash and sticky halt.
module decode_stage #(
  parameter int LU_STALL = 1
) (
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave fe,
  output logic [2:0]    rf_ra1,
  output logic [2:0]    rf_ra2,
  input  logic [15:0]   rf_rd1,
  input  logic [15:0]   rf_rd2,
  input  logic          ex_ready,
  input  logic          alu_flush,
  input  logic          alu_hlt,
  output logic          ex_valid,
  output logic [1:0]    ex_op1,
  output logic [2:0]    ex_op2,
  output logic [2:0]    ex_cond,
  output logic [3:0]    ex_opcode,
  output logic [3:0]    ex_d,
  output logic [15:0]   ex_in1,
  output logic [15:0]   ex_in2,
  output logic [15:0]   ex_st_data,
  output logic          ex_wr_en,
  output logic [2:0]    ex_wr_addr,
  output logic          ex_mem_rd,
  output logic          ex_mem_wr,
  output logic          halted
);

  typedef struct packed {
    logic        valid;
    logic [1:0]  op1;
    logic [2:0]  op2;
    logic [2:0]  cond;
    logic [3:0]  opcode;
    logic [3:0]  d;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [15:0] st_data;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic        mem_rd;
    logic        mem_wr;
  } slot_t;

  localparam logic [1:0] STALL_LD = 2'(LU_STALL - 1);

  slot_t       slot, slot_nxt, dec;
  logic [1:0]  cnt, cnt_nxt;
  logic        halt_nxt;
  logic        use_a, use_b, hazard;
  logic [15:0] inst, sx;

  assign inst   = fe.if_inst;
  assign sx     = {{8{inst[7]}}, inst[7:0]};
  assign rf_ra1 = inst[10:8];
  assign rf_ra2 = inst[13:11];

  // Decode the IF word into a candidate slot and its source usage.
  always_comb begin
    dec         = '0;
    dec.valid   = 1'b1;
    dec.op1     = inst[15:14];
    dec.op2     = inst[13:11];
    dec.cond    = inst[10:8];
    dec.opcode  = inst[7:4];
    dec.d       = inst[3:0];
    dec.st_data = rf_rd2;
    use_a       = 1'b0;
    use_b       = 1'b0;
    unique case (inst[15:14])
      2'b11: begin
        dec.in1     = rf_rd1;
        dec.in2     = rf_rd2;
        dec.wr_addr = inst[10:8];
        dec.wr_en   = !(inst[7:4] inside {4'b0101, 4'b0111, [4'b1100:4'b1111]});
        use_a       = 1'b1;
        use_b       = 1'b1;
      end
      2'b00: begin
        dec.in1     = rf_rd1;
        dec.in2     = sx;
        dec.mem_rd  = 1'b1;
        dec.wr_en   = 1'b1;
        dec.wr_addr = inst[13:11];
        use_b       = 1'b1;
      end
      2'b01: begin
        dec.in1     = rf_rd1;
        dec.in2     = sx;
        dec.mem_wr  = 1'b1;
        dec.wr_addr = inst[13:11];
        use_a       = 1'b1;
        use_b       = 1'b1;
      end
      2'b10: begin
        dec.wr_addr = inst[10:8];
        use_b       = (inst[13:11] != 3'b000);
        unique case (inst[13:11])
          3'b000, 3'b001: begin
            dec.in1   = rf_rd1;
            dec.in2   = sx;
            dec.wr_en = 1'b1;
          end
          3'b010: begin
            dec.in1 = rf_rd1;
            dec.in2 = sx;
          end
          3'b100, 3'b110, 3'b111: begin
            dec.in1 = fe.if_pc1;
            dec.in2 = sx;
          end
          3'b101: dec.in1 = fe.if_pc1;
          3'b011: dec.in1 = '0;
        endcase
      end
    endcase
  end

  // A live load in the slot feeding a source of the IF word.
  always_comb begin
    hazard = fe.if_valid & slot.valid & slot.mem_rd &
             ((use_a & (slot.wr_addr == inst[13:11])) |
              (use_b & (slot.wr_addr == inst[10:8])));
  end

  // Per-cycle priority: halt, halt request, back-pressure,
  // flush, stall, issue.
  always_comb begin
    slot_nxt    = '0;
    cnt_nxt     = cnt;
    halt_nxt    = halted;
    fe.if_ready = 1'b0;
    if (halted) begin
      slot_nxt = '0;
    end else if (alu_hlt & slot.valid & ex_ready) begin
      halt_nxt = 1'b1;
    end else if (!ex_ready) begin
      slot_nxt = slot;
    end else if (alu_flush & slot.valid) begin
      fe.if_ready = 1'b1;
      cnt_nxt     = '0;
    end else if (cnt != 2'd0) begin
      cnt_nxt = cnt - 2'd1;
    end else if (hazard) begin
      cnt_nxt = STALL_LD;
    end else if (fe.if_valid) begin
      slot_nxt    = dec;
      fe.if_ready = 1'b1;
    end
  end

  // ID/EX slot, stall counter and halt flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot   <= '0;
      cnt    <= '0;
      halted <= 1'b0;
    end else begin
      slot   <= slot_nxt;
      cnt    <= cnt_nxt;
      halted <= halt_nxt;
    end
  end

  assign ex_valid   = slot.valid;
  assign ex_op1     = slot.op1;
  assign ex_op2     = slot.op2;
  assign ex_cond    = slot.cond;
  assign ex_opcode  = slot.opcode;
  assign ex_d       = slot.d;
  assign ex_in1     = slot.in1;
  assign ex_in2     = slot.in2;
  assign ex_st_data = slot.st_data;
  assign ex_wr_en   = slot.wr_en;
  assign ex_wr_addr = slot.wr_addr;
  assign ex_mem_rd  = slot.mem_rd;
  assign ex_mem_wr  = slot.mem_wr;

endmodule
